ysyx_23060332_wbu: RTL and testbench
====================================

// Module: ysyx_23060332_wbu
// PURPOSE
//  Writeback unit: the single writer of the 2R1W register file's write port (reg_wen/waddr/wdata).
//  Accepts results from EXU (ALU/CSR/jump link) and LSU (load data) over valid/ready channels.
//  Buffers one result per source, performs load byte/half extraction and sign/zero extension,
//  arbitrates one regfile write per cycle and emits a commit pulse for difftest/trace.
// PARAMETERS
//  (none; widths come from `RegAddrBus (5b) / `RegDataBus (32b) in ysyx_23060332_define.v)
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  exu_valid    in   1   EXU result valid
//  exu_ready    out  1   WBU can take EXU result this cycle
//  exu_wen      in   1   result targets a register (0: commit only, no write)
//  exu_rd       in   5   destination register
//  exu_data     in   32  result value
//  lsu_valid    in   1   LSU load result valid
//  lsu_ready    out  1   WBU can take LSU result this cycle
//  lsu_rd       in   5   destination register
//  lsu_rdata    in   32  raw aligned 32-bit word from memory
//  lsu_addr_lo  in   2   load address bits [1:0]
//  lsu_funct3   in   3   load type: LB 000, LH 001, LW 010, LBU 100, LHU 101
//  reg_wen      out  1   regfile write enable
//  waddr        out  5   regfile write address
//  wdata        out  32  regfile write data
//  commit_valid out  1   one-cycle pulse per retired result (written or not)
//  commit_src   out  1   0 = EXU, 1 = LSU (valid with commit_valid)
//  load_err     out  1   one-cycle pulse: retired LSU result was misaligned or illegal funct3
//  busy         out  1   either holding slot occupied
// BEHAVIOUR
//  - Slots: one holding register per source (valid bit + rd + wen + data; LSU also addr_lo, funct3).
//  - Handshake: transfer when X_valid && X_ready at posedge; X_ready = ~slotX_full | drainX
//    (slot draining this cycle may be refilled same edge). Inputs must be stable while valid && ~ready.
//  - Latency: accepted at edge N -> slot full in cycle N+1 -> outputs asserted combinationally in
//    cycle N+1 -> regfile updated at edge N+2 if granted. Back-to-back: 1 result/cycle sustained.
//  - Arbitration: one drain per cycle. Only one slot full -> it drains. Both full -> round-robin:
//    grant source != last_src; last_src updates on every drain. After reset last_src=LSU (EXU first).
//  - Outputs combinational from granted slot: reg_wen = granted & wen & (rd != 0); waddr = rd;
//    wdata = EXU data or extracted load value; commit_valid = any drain; commit_src = grantee.
//  - Load extract: shift = addr_lo*8; LB/LBU byte sign/zero-ext; LH/LHU half sign/zero-ext; LW word.
//  - Errors: LH/LHU with addr_lo==3, LW with addr_lo!=0, funct3 in {011,110,111} -> reg_wen=0,
//    commit_valid=1, load_err=1 in the drain cycle.
//  - rd==0 or exu_wen==0: slot drains, commit pulses, reg_wen stays 0 (x0 never written).
//  - Idle (no slot full): reg_wen=0, waddr=0, wdata=0, commit_valid=0, commit_src=0, load_err=0.
//  - Reset (any time, incl. mid-operation): both slots cleared (pending results dropped),
//    last_src=LSU; during rst cycle exu_ready=lsu_ready=0, all outputs at idle values, busy=0.
// CONFIGURATION
//  YSYX_23060332_WBU_BYPASS_EN defined: adds ports raddr1/raddr2 in 5b, byp_hit1/byp_hit2 out 1b,
//   byp_data1/byp_data2 out 32b; byp_hitK = reg_wen & (waddr==raddrK) & (raddrK!=0), byp_dataK = wdata
//   (same-cycle write-to-read forwarding for IDU; regfile reads return pre-write value).
//  Not defined: those ports absent; IDU must stall on RAW against busy results.
// STRUCTURE
//  - ysyx_23060332_define.v: add `LOAD_LB/LH/LW/LBU/LHU funct3 codes, `WB_SRC_EXU=1'b0 / `WB_SRC_LSU=1'b1.
//  - Sub-module ysyx_23060332_load_ext: combinational (rdata, addr_lo, funct3) -> (data, err).
//  - Top holds two slots, round-robin bit, grant/drain logic, output mux.
// TESTING
//  1. EXU rd=5 data=0xDEADBEEF wen=1 -> next cycle reg_wen=1 waddr=5 wdata=0xDEADBEEF commit_src=0.
//  2. LSU LB addr_lo=2 rdata=0x1280_3456 -> wdata=0xFFFFFF80; LHU addr_lo=2 same word -> 0x00001280.
//  3. Both valid every cycle for 8 cycles -> commits alternate EXU,LSU,EXU,...; no loss; readies toggle.
//  4. EXU rd=0 data=0x1 -> commit_valid=1, reg_wen=0; LSU LW addr_lo=1 -> load_err=1, reg_wen=0.
//  5. Both slots full, rst asserted 1 cycle -> busy=0, no commit next cycle; next EXU result drains first.
//  6. BYPASS_EN: EXU writes x7=0x55 while raddr2=7 -> byp_hit2=1 byp_data2=0x55; raddr1=0 -> byp_hit1=0.

Source files
------------

// File: rtl/ysyx_23060332_wbu_pkg.sv
// ============================================================================
// Module  : ysyx_23060332_wbu_pkg
// Brief   : Shared widths, load funct3 codes, writeback source codes and the
//           holding-slot record types used by the writeback unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_23060332_wbu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  // Load type encodings (instruction funct3 field)
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  // Writeback source identifiers (also the commit_src encoding)
  localparam logic WB_SRC_EXU = 1'b0;
  localparam logic WB_SRC_LSU = 1'b1;

  // Holding register for one EXU result
  typedef struct packed {
    logic                  full;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
    logic [REG_DATA_W-1:0] data;
  } exu_slot_t;

  // Holding register for one raw LSU load result; extraction happens on drain
  typedef struct packed {
    logic                  full;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] rdata;
    logic [1:0]            addr_lo;
    logic [2:0]            funct3;
  } lsu_slot_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060332_load_ext.sv
// ============================================================================
// Module  : ysyx_23060332_load_ext
// Brief   : Combinational load data extraction. Selects the addressed
//           byte/half/word from an aligned 32-bit memory word, sign- or
//           zero-extends it, and flags misaligned or unknown load types.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060332_load_ext
  import ysyx_23060332_wbu_pkg::*;
(
  input  logic [REG_DATA_W-1:0] i_rdata,
  input  logic [1:0]            i_addr_lo,
  input  logic [2:0]            i_funct3,
  output logic [REG_DATA_W-1:0] o_data,
  output logic                  o_err
);

  logic [REG_DATA_W-1:0] w_shifted;

  // Bring the addressed byte/half down to bit 0
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  // Decode load type: extension and alignment check
  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_funct3)
      LOAD_LB:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LOAD_LBU: o_data = {24'b0, w_shifted[7:0]};
      LOAD_LH: begin
        o_err  = (i_addr_lo == 2'd3);
        o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      LOAD_LHU: begin
        o_err  = (i_addr_lo == 2'd3);
        o_data = {16'b0, w_shifted[15:0]};
      end
      LOAD_LW: begin
        o_err  = (i_addr_lo != 2'd0);
        o_data = i_rdata;
      end
      default:  o_err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060332_wbu.sv
// ============================================================================
// Module  : ysyx_23060332_wbu
// Brief   : Writeback unit. Holds one EXU and one LSU result, round-robins
//           them onto the single regfile write port (one per cycle), and
//           pulses commit/load_err for each retired result.
//           Optional macro YSYX_23060332_WBU_BYPASS_EN adds same-cycle
//           write-to-read forwarding ports for the decode stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060332_wbu
  import ysyx_23060332_wbu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [REG_ADDR_W-1:0] exu_rd,
  input  logic [REG_DATA_W-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [REG_DATA_W-1:0] lsu_rdata,
  input  logic [1:0]            lsu_addr_lo,
  input  logic [2:0]            lsu_funct3,
  output logic                  reg_wen,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [REG_DATA_W-1:0] wdata,
  output logic                  commit_valid,
  output logic                  commit_src,
  output logic                  load_err,
  output logic                  busy
`ifdef YSYX_23060332_WBU_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [REG_DATA_W-1:0] byp_data1,
  output logic [REG_DATA_W-1:0] byp_data2
`endif
);

  exu_slot_t exu_q, exu_d;
  lsu_slot_t lsu_q, lsu_d;
  logic      last_src_q, last_src_d;

  logic      grant_src;
  logic      drain_exu;
  logic      drain_lsu;

  logic [REG_DATA_W-1:0] ld_data;
  logic                  ld_err;

  ysyx_23060332_load_ext u_load_ext (
    .i_rdata   (lsu_q.rdata),
    .i_addr_lo (lsu_q.addr_lo),
    .i_funct3  (lsu_q.funct3),
    .o_data    (ld_data),
    .o_err     (ld_err)
  );

  // Pick one slot to drain; reset suppresses draining so pending results drop
  always_comb begin
    grant_src = WB_SRC_EXU;
    drain_exu = 1'b0;
    drain_lsu = 1'b0;
    if (!rst) begin
      if (exu_q.full && lsu_q.full) begin
        grant_src = (last_src_q == WB_SRC_LSU) ? WB_SRC_EXU : WB_SRC_LSU;
      end else if (lsu_q.full) begin
        grant_src = WB_SRC_LSU;
      end
      drain_exu = exu_q.full && (grant_src == WB_SRC_EXU);
      drain_lsu = lsu_q.full && (grant_src == WB_SRC_LSU);
    end
  end

  // A slot can accept when empty or when it is being drained this cycle
  assign exu_ready = ~rst & (~exu_q.full | drain_exu);
  assign lsu_ready = ~rst & (~lsu_q.full | drain_lsu);
  assign busy      = ~rst & (exu_q.full | lsu_q.full);

  // Drive the regfile write port and commit signals from the drained slot
  always_comb begin
    reg_wen      = 1'b0;
    waddr        = '0;
    wdata        = '0;
    commit_valid = 1'b0;
    commit_src   = WB_SRC_EXU;
    load_err     = 1'b0;
    if (drain_exu) begin
      reg_wen      = exu_q.wen && (exu_q.rd != '0);
      waddr        = exu_q.rd;
      wdata        = exu_q.data;
      commit_valid = 1'b1;
      commit_src   = WB_SRC_EXU;
    end else if (drain_lsu) begin
      reg_wen      = !ld_err && (lsu_q.rd != '0);
      waddr        = lsu_q.rd;
      wdata        = ld_data;
      commit_valid = 1'b1;
      commit_src   = WB_SRC_LSU;
      load_err     = ld_err;
    end
  end

  // Slot and round-robin next state: drain first, then same-edge refill
  always_comb begin
    exu_d      = exu_q;
    lsu_d      = lsu_q;
    last_src_d = last_src_q;
    if (drain_exu) exu_d.full = 1'b0;
    if (drain_lsu) lsu_d.full = 1'b0;
    if (drain_exu || drain_lsu) last_src_d = grant_src;
    if (exu_valid && exu_ready) begin
      exu_d.full = 1'b1;
      exu_d.rd   = exu_rd;
      exu_d.wen  = exu_wen;
      exu_d.data = exu_data;
    end
    if (lsu_valid && lsu_ready) begin
      lsu_d.full    = 1'b1;
      lsu_d.rd      = lsu_rd;
      lsu_d.rdata   = lsu_rdata;
      lsu_d.addr_lo = lsu_addr_lo;
      lsu_d.funct3  = lsu_funct3;
    end
  end

  // State registers; reset empties both slots and favours EXU next
  always_ff @(posedge clk) begin
    if (rst) begin
      exu_q      <= '0;
      lsu_q      <= '0;
      last_src_q <= WB_SRC_LSU;
    end else begin
      exu_q      <= exu_d;
      lsu_q      <= lsu_d;
      last_src_q <= last_src_d;
    end
  end

`ifdef YSYX_23060332_WBU_BYPASS_EN
  // Forward the value being written this cycle to decode-stage readers
  assign byp_hit1  = reg_wen & (waddr == raddr1) & (raddr1 != '0);
  assign byp_hit2  = reg_wen & (waddr == raddr2) & (raddr2 != '0);
  assign byp_data1 = wdata;
  assign byp_data2 = wdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060332_wbu.sv
// ============================================================================
// Module  : tb_ysyx_23060332_wbu
// Brief   : Self-checking bench for the writeback unit: queue-based model
//           checked every cycle plus directed literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060332_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_addr_lo;
  logic [2:0]  lsu_funct3;
  logic        exu_ready, lsu_ready;
  logic        reg_wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        commit_valid, commit_src, load_err, busy;
`ifdef YSYX_23060332_WBU_BYPASS_EN
  logic [4:0]  raddr1, raddr2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060332_wbu dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_rdata(lsu_rdata), .lsu_addr_lo(lsu_addr_lo), .lsu_funct3(lsu_funct3),
    .reg_wen(reg_wen), .waddr(waddr), .wdata(wdata),
    .commit_valid(commit_valid), .commit_src(commit_src),
    .load_err(load_err), .busy(busy)
`ifdef YSYX_23060332_WBU_BYPASS_EN
    ,
    .raddr1(raddr1), .raddr2(raddr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of a load: pick the addressed lane, then extend
  function automatic void model_load(input logic [31:0] w, input logic [1:0] a,
                                     input logic [2:0] f, output logic [31:0] v,
                                     output logic e);
    logic [63:0] wx;
    logic [7:0]  b;
    logic [15:0] h;
    wx = {32'b0, w};
    b  = wx[8*a +: 8];
    h  = wx[8*a +: 16];
    e  = 1'b0;
    v  = 32'b0;
    case (f)
      3'b000: v = {{24{b[7]}}, b};
      3'b100: v = {24'b0, b};
      3'b001: begin e = (a == 2'd3); v = {{16{h[15]}}, h}; end
      3'b101: begin e = (a == 2'd3); v = {16'b0, h}; end
      3'b010: begin e = (a != 2'd0); v = w; end
      default: e = 1'b1;
    endcase
  endfunction

  // ---------------- model: one pending queue per source -----------------
  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic [1:0]  a;
    logic [2:0]  f;
  } item_t;

  item_t eq[$];
  item_t lq[$];
  bit    last_lsu = 1'b1;
  bit    commit_log[$];

  // Compare on the falling edge, advance the model on the rising edge
  always begin
    bit          he, hl, g, any, rr, e_rdy, l_rdy, exp_wen, exp_err, acc_e, acc_l;
    logic [31:0] exp_wd, v;
    logic        e;
    logic [4:0]  exp_wa;
    item_t       it, ne, nl;
    @(negedge clk);
    rr  = (rst === 1'b1);
    he  = !rr && eq.size() > 0;
    hl  = !rr && lq.size() > 0;
    any = he || hl;
    g   = (he && hl) ? !last_lsu : hl;
    e_rdy = !rr && (eq.size() == 0 || (any && g == 1'b0));
    l_rdy = !rr && (lq.size() == 0 || (any && g == 1'b1));
    exp_wen = 0; exp_err = 0; exp_wd = 0; exp_wa = 0;
    if (any) begin
      if (g == 1'b0) begin
        it = eq[0];
        exp_wen = it.wen && it.rd != 0;
        exp_wd  = it.data;
      end else begin
        it = lq[0];
        model_load(it.data, it.a, it.f, v, e);
        exp_err = e;
        exp_wen = !e && it.rd != 0;
        exp_wd  = v;
      end
      exp_wa = it.rd;
    end
    check("exu_ready", {31'b0, exu_ready}, {31'b0, e_rdy});
    check("lsu_ready", {31'b0, lsu_ready}, {31'b0, l_rdy});
    check("busy", {31'b0, busy}, {31'b0, any});
    check("commit_valid", {31'b0, commit_valid}, {31'b0, any});
    check("commit_src", {31'b0, commit_src}, {31'b0, any & g});
    check("reg_wen", {31'b0, reg_wen}, {31'b0, exp_wen});
    check("load_err", {31'b0, load_err}, {31'b0, exp_err});
    check("waddr", {27'b0, waddr}, {27'b0, exp_wa});
    if (!exp_err) check("wdata", wdata, exp_wd);
    if (commit_valid === 1'b1) commit_log.push_back(commit_src);
    acc_e = exu_valid && e_rdy;
    acc_l = lsu_valid && l_rdy;
    ne = '{exu_rd, exu_wen, exu_data, 2'b0, 3'b0};
    nl = '{lsu_rd, 1'b1, lsu_rdata, lsu_addr_lo, lsu_funct3};
    @(posedge clk);
    if (rr) begin
      eq.delete(); lq.delete(); last_lsu = 1'b1;
    end else begin
      if (any) begin
        if (g == 1'b0) void'(eq.pop_front()); else void'(lq.pop_front());
        last_lsu = g;
      end
      if (acc_e) eq.push_back(ne);
      if (acc_l) lq.push_back(nl);
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) -------------
  task automatic exu_send(input logic [4:0] rd, input logic [31:0] d, input logic w);
    bit ok = 0;
    exu_valid = 1; exu_rd = rd; exu_data = d; exu_wen = w;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exu_ready === 1'b1) begin ok = 1; break; end
    end
    check("exu_accept", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    exu_valid = 0;
  endtask

  task automatic lsu_send(input logic [4:0] rd, input logic [31:0] w,
                          input logic [1:0] a, input logic [2:0] f);
    bit ok = 0;
    lsu_valid = 1; lsu_rd = rd; lsu_rdata = w; lsu_addr_lo = a; lsu_funct3 = f;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (lsu_ready === 1'b1) begin ok = 1; break; end
    end
    check("lsu_accept", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    lsu_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; exu_valid = 0; exu_wen = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_addr_lo = 0; lsu_funct3 = 0;
`ifdef YSYX_23060332_WBU_BYPASS_EN
    raddr1 = 0; raddr2 = 0;
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_exu_ready", {31'b0, exu_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // 1: plain EXU write
    exu_send(5'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("t1_wen", {31'b0, reg_wen}, 32'd1);
    check("t1_waddr", {27'b0, waddr}, 32'd5);
    check("t1_wdata", wdata, 32'hDEADBEEF);
    check("t1_src", {31'b0, commit_src}, 32'd0);
    @(posedge clk); #1;

    // 2: load extraction
    lsu_send(5'd3, 32'h1280_3456, 2'd2, 3'b000);
    @(negedge clk);
    check("t2_lb", wdata, 32'hFFFFFF80);
    check("t2_lb_src", {31'b0, commit_src}, 32'd1);
    @(posedge clk); #1;
    lsu_send(5'd3, 32'h1280_3456, 2'd2, 3'b101);
    @(negedge clk);
    check("t2_lhu", wdata, 32'h00001280);
    @(posedge clk); #1;
    lsu_send(5'd4, 32'h1280_3456, 2'd0, 3'b001);
    @(negedge clk);
    check("t2_lh0", wdata, 32'h00003456);
    @(posedge clk); #1;
    lsu_send(5'd4, 32'h1280_3456, 2'd3, 3'b100);
    @(negedge clk);
    check("t2_lbu3", wdata, 32'h00000012);
    @(posedge clk); #1;

    // 4: x0 target, misaligned and illegal loads
    exu_send(5'd0, 32'h1, 1'b1);
    @(negedge clk);
    check("t4_x0_commit", {31'b0, commit_valid}, 32'd1);
    check("t4_x0_wen", {31'b0, reg_wen}, 32'd0);
    @(posedge clk); #1;
    exu_send(5'd9, 32'h77, 1'b0);
    @(negedge clk);
    check("t4_nowen", {31'b0, reg_wen}, 32'd0);
    @(posedge clk); #1;
    lsu_send(5'd6, 32'hCAFEF00D, 2'd1, 3'b010);
    @(negedge clk);
    check("t4_lw_err", {31'b0, load_err}, 32'd1);
    check("t4_lw_wen", {31'b0, reg_wen}, 32'd0);
    check("t4_lw_commit", {31'b0, commit_valid}, 32'd1);
    @(posedge clk); #1;
    lsu_send(5'd6, 32'hCAFEF00D, 2'd3, 3'b001);
    @(negedge clk);
    check("t4_lh3_err", {31'b0, load_err}, 32'd1);
    @(posedge clk); #1;
    lsu_send(5'd6, 32'hCAFEF00D, 2'd0, 3'b110);
    @(negedge clk);
    check("t4_f110_err", {31'b0, load_err}, 32'd1);
    @(posedge clk); #1;

    // 3: both sources streaming, strict alternation from reset
    do_reset();
    commit_log.delete();
    fork
      for (int i = 0; i < 8; i++) exu_send(5'd1 + 5'(i), 32'h100 + i, 1'b1);
      for (int j = 0; j < 8; j++) lsu_send(5'd10 + 5'(j), 32'h2000 + j, 2'd0, 3'b010);
    join
    repeat (4) @(posedge clk); #1;
    check("t3_count", commit_log.size(), 32'd16);
    for (int i = 0; i < 16 && i < commit_log.size(); i++)
      check("t3_order", {31'b0, commit_log[i]}, i % 2);

    // 5: reset with both slots holding results
    exu_valid = 1; exu_rd = 5'd2; exu_data = 32'hAAAA; exu_wen = 1;
    lsu_valid = 1; lsu_rd = 5'd3; lsu_rdata = 32'hBBBB; lsu_addr_lo = 0; lsu_funct3 = 3'b010;
    @(negedge clk);
    check("t5_both_ready", {30'b0, exu_ready, lsu_ready}, 32'd3);
    @(posedge clk); #1;
    exu_valid = 0; lsu_valid = 0; rst = 1;
    @(negedge clk);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_commit", {31'b0, commit_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("t5_post_busy", {31'b0, busy}, 32'd0);
    check("t5_post_commit", {31'b0, commit_valid}, 32'd0);
    @(posedge clk); #1;
    commit_log.delete();
    fork
      exu_send(5'd8, 32'h1234, 1'b1);
      lsu_send(5'd9, 32'h5678, 2'd0, 3'b010);
    join
    repeat (3) @(posedge clk); #1;
    check("t5_count", commit_log.size(), 32'd2);
    if (commit_log.size() > 0) check("t5_first_exu", {31'b0, commit_log[0]}, 32'd0);

`ifdef YSYX_23060332_WBU_BYPASS_EN
    // 6: same-cycle forwarding
    raddr1 = 5'd0; raddr2 = 5'd7;
    exu_send(5'd7, 32'h55, 1'b1);
    @(negedge clk);
    check("t6_hit2", {31'b0, byp_hit2}, 32'd1);
    check("t6_data2", byp_data2, 32'h55);
    check("t6_hit1", {31'b0, byp_hit1}, 32'd0);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
